alarm_zone_ctrl: RTL and testbench

Parametrised successor to the fixed three-sensor alarm top. Handles N_ZONES sensor zones, each synchronised and debounced, with a per-zone instant/delayed mode. A multi-digit keypad code arms and disarms the system. Entry, exit and siren timeouts are counted on an internal clock-enable tick. It sits directly behind the board pins, and its outputs drive the siren and status LEDs.

---
 rtl/alarm_zone_ctrl_pkg.sv | 24 ++
 rtl/alarm_zone_ctrl_if.sv | 32 +++
 rtl/alarm_zone_ctrl_zone_debounce.sv | 56 +++++
 rtl/alarm_zone_ctrl.sv | 170 +++++++++++++++++
 tb/tb_alarm_zone_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_zone_ctrl_pkg.sv
// Shared types for the alarm zone controller: FSM state encoding and keypad code type.
package alarm_pkg;

  typedef enum logic [2:0] {
    DISARMED,
    EXIT_DELAY,
    ARMED,
    ENTRY_DELAY,
    ALARM
  } alarm_state_t;

  typedef logic [3:0] key_t;

  localparam key_t KEY_NONE = 4'h0;

  function automatic logic state_is_armed(alarm_state_t s);
    return (s == ARMED) || (s == ENTRY_DELAY) || (s == ALARM);
  endfunction

  function automatic logic state_is_waiting(alarm_state_t s);
    return (s == EXIT_DELAY) || (s == ENTRY_DELAY);
  endfunction

endpackage

// File: rtl/alarm_zone_ctrl_if.sv
// Pin-side bundle of the alarm controller: raw sensor/keypad inputs and siren/LED outputs.
interface alarm_zone_ctrl_if #(
  parameter int N_ZONES = 3
);
  import alarm_pkg::*;

  logic [N_ZONES-1:0] zone_in;
  key_t               keypad_in;
  logic               alarm_siren;
  logic               is_armed;
  logic               is_wait_delay;
  logic [N_ZONES-1:0] zone_tripped;

  modport master (
    output zone_in,
    output keypad_in,
    input  alarm_siren,
    input  is_armed,
    input  is_wait_delay,
    input  zone_tripped
  );

  modport slave (
    input  zone_in,
    input  keypad_in,
    output alarm_siren,
    output is_armed,
    output is_wait_delay,
    output zone_tripped
  );

endinterface

// File: rtl/alarm_zone_ctrl_zone_debounce.sv
// One sensor zone: two-flop synchroniser followed by a tick-sampled run-length debouncer.
module zone_debounce
  import alarm_pkg::*;
#(
  parameter int DEB_TICKS = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level
);

  localparam int RUN_W = (DEB_TICKS > 1) ? $clog2(DEB_TICKS + 1) : 1;

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;

  always_comb begin
    level_d = level_q;
    run_d   = run_q;
    if (tick) begin
      if (sync2_q != level_q) begin
        if (run_q == RUN_W'(DEB_TICKS - 1)) begin
          level_d = sync2_q;
          run_d   = '0;
        end else begin
          run_d = run_q + RUN_W'(1);
        end
      end else begin
        run_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      run_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      run_q   <= run_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/alarm_zone_ctrl.sv
// Alarm zone controller: tick generator, keypad edge detect, code matcher and arming FSM.
module alarm_zone_ctrl
  import alarm_pkg::*;
#(
  parameter int                    N_ZONES      = 3,
  parameter int                    DIVIDER      = 2_500_000,
  parameter int                    DEB_TICKS    = 2,
  parameter int                    CODE_LEN     = 4,
  parameter logic [4*CODE_LEN-1:0] CODE         = 16'h1234,
  parameter logic [N_ZONES-1:0]    DELAYED_MASK = 3'b100,
  parameter int                    EXIT_TICKS   = 20,
  parameter int                    ENTRY_TICKS  = 20,
  parameter int                    SIREN_TICKS  = 100
) (
  input logic               clk,
  input logic               reset,
  alarm_zone_ctrl_if.slave  bus
);

  localparam int DIV_W   = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int TMR_MAX = (EXIT_TICKS > ENTRY_TICKS)
                           ? ((EXIT_TICKS > SIREN_TICKS) ? EXIT_TICKS : SIREN_TICKS)
                           : ((ENTRY_TICKS > SIREN_TICKS) ? ENTRY_TICKS : SIREN_TICKS);
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;

  logic [DIV_W-1:0]   div_q, div_d;
  logic               tick;
  key_t               key_s1_q, key_s2_q, key_prev_q;
  logic               key_event;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_adv;
  logic               code_ok;
  key_t               code_digit [CODE_LEN];
  logic [N_ZONES-1:0] zone_lvl;
  alarm_state_t       state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               expired;
  logic [N_ZONES-1:0] tripped_q, tripped_d;
  logic               siren_q, armed_q, wait_q;

  always_comb begin
    tick  = (div_q == DIV_W'(DIVIDER - 1));
    div_d = tick ? '0 : div_q + DIV_W'(1);
  end

  generate
    for (genvar gi = 0; gi < N_ZONES; gi++) begin : g_zone
      zone_debounce #(
        .DEB_TICKS (DEB_TICKS)
      ) u_deb (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .raw   (bus.zone_in[gi]),
        .level (zone_lvl[gi])
      );
    end
    // Digit 0 lives in the most significant nibble of CODE.
    for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_digit
      assign code_digit[gi] = CODE[4*(CODE_LEN-1-gi) +: 4];
    end
  endgenerate

  assign key_event = (key_s2_q != KEY_NONE) && (key_prev_q == KEY_NONE);

  always_comb begin
    code_ok = 1'b0;
    idx_adv = idx_q;
    if (key_event) begin
      if (key_s2_q == code_digit[idx_q]) begin
        if (idx_q == IDX_W'(CODE_LEN - 1)) begin
          code_ok = 1'b1;
          idx_adv = '0;
        end else begin
          idx_adv = idx_q + IDX_W'(1);
        end
      end else begin
        idx_adv = '0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    tripped_d = tripped_q;
    // A loaded count of 0 or 1 both expire on the first tick after entry.
    expired   = tick && (tmr_q <= TMR_W'(1));
    if (tick && !expired) begin
      tmr_d = tmr_q - TMR_W'(1);
    end
    case (state_q)
      DISARMED: begin
        if (code_ok) state_d = EXIT_DELAY;
      end
      EXIT_DELAY: begin
        if (code_ok)      state_d = DISARMED;
        else if (expired) state_d = ARMED;
      end
      ARMED: begin
        if (code_ok) begin
          state_d = DISARMED;
        end else begin
          tripped_d = tripped_q | zone_lvl;
          if (|(zone_lvl & ~DELAYED_MASK))     state_d = ALARM;
          else if (|(zone_lvl & DELAYED_MASK)) state_d = ENTRY_DELAY;
        end
      end
      ENTRY_DELAY: begin
        if (code_ok) begin
          state_d = DISARMED;
        end else begin
          tripped_d = tripped_q | zone_lvl;
          if (|(zone_lvl & ~DELAYED_MASK)) state_d = ALARM;
          else if (expired)                state_d = ALARM;
        end
      end
      ALARM: begin
        if (code_ok)      state_d = DISARMED;
        else if (expired) state_d = ARMED;
      end
      default: state_d = DISARMED;
    endcase
    if (state_d != state_q) begin
      case (state_d)
        EXIT_DELAY:  tmr_d = TMR_W'(EXIT_TICKS);
        ENTRY_DELAY: tmr_d = TMR_W'(ENTRY_TICKS);
        ALARM:       tmr_d = TMR_W'(SIREN_TICKS);
        default:     tmr_d = '0;
      endcase
      if (state_d == DISARMED) tripped_d = '0;
    end
  end

  assign idx_d = (state_d != state_q) ? '0 : idx_adv;

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q      <= '0;
      key_s1_q   <= KEY_NONE;
      key_s2_q   <= KEY_NONE;
      key_prev_q <= KEY_NONE;
      idx_q      <= '0;
      state_q    <= DISARMED;
      tmr_q      <= '0;
      tripped_q  <= '0;
      siren_q    <= 1'b0;
      armed_q    <= 1'b0;
      wait_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      key_s1_q   <= bus.keypad_in;
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_s2_q;
      idx_q      <= idx_d;
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      tripped_q  <= tripped_d;
      siren_q    <= (state_d == ALARM);
      armed_q    <= state_is_armed(state_d);
      wait_q     <= state_is_waiting(state_d);
    end
  end

  assign bus.alarm_siren   = siren_q;
  assign bus.is_armed      = armed_q;
  assign bus.is_wait_delay = wait_q;
  assign bus.zone_tripped  = tripped_q;

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Directed scenarios plus randomized key/zone traffic, checked every cycle against a tick-counting model.
module tb_alarm_zone_ctrl;
  import alarm_pkg::*;

  localparam int NZ = 3, DIV = 4, DEB = 2, CLEN = 4, EXT = 3, ENT = 3, SIR = 5;
  localparam logic [15:0] CODE_V = 16'h1234;
  localparam logic [2:0]  DMASK  = 3'b100;
  localparam int M_DIS = 0, M_EXIT = 1, M_ARM = 2, M_ENT = 3, M_ALM = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alarm_zone_ctrl_if #(.N_ZONES(NZ)) bus ();

  alarm_zone_ctrl #(
    .N_ZONES(NZ), .DIVIDER(DIV), .DEB_TICKS(DEB), .CODE_LEN(CLEN), .CODE(CODE_V),
    .DELAYED_MASK(DMASK), .EXIT_TICKS(EXT), .ENTRY_TICKS(ENT), .SIREN_TICKS(SIR)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0, errors = 0;

  int m_state, m_ticks, m_prog, m_n;
  int m_streak [NZ];
  logic [2:0] m_zs1, m_zs2, m_lvl, m_trip;
  logic [3:0] m_ks1, m_ks2, m_kprev;
  bit m_valid = 1'b0;

  function automatic logic [3:0] code_digit(int p);
    logic [15:0] c;
    c = CODE_V;
    return c[4*(CLEN-1-p) +: 4];
  endfunction

  function automatic logic [7:0] outs();
    return {2'b00, bus.alarm_siren, bus.is_armed, bus.is_wait_delay, bus.zone_tripped};
  endfunction

  function automatic logic [7:0] m_exp();
    logic s, a, w;
    s = (m_state == M_ALM);
    a = (m_state == M_ARM) || (m_state == M_ENT) || (m_state == M_ALM);
    w = (m_state == M_EXIT) || (m_state == M_ENT);
    return {2'b00, s, a, w, m_trip};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one rising edge, using the inputs held since the last negedge.
  task automatic model_edge();
    bit tick, kev, ok, expd;
    int nst, nprog, lim;
    logic [2:0] ntrip, inst, dly;
    if (reset == 1'b0) begin
      m_state = M_DIS; m_ticks = 0; m_prog = 0; m_n = 0;
      m_zs1 = '0; m_zs2 = '0; m_lvl = '0; m_trip = '0;
      m_ks1 = '0; m_ks2 = '0; m_kprev = '0;
      for (int z = 0; z < NZ; z++) m_streak[z] = 0;
      m_valid = 1'b1;
      return;
    end
    tick = ((m_n % DIV) == DIV - 1);
    kev  = (m_ks2 != 4'h0) && (m_kprev == 4'h0);
    ok = 1'b0;
    nprog = m_prog;
    if (kev) begin
      if (m_ks2 == code_digit(m_prog)) begin
        nprog++;
        if (nprog == CLEN) begin ok = 1'b1; nprog = 0; end
      end else begin
        nprog = 0;
      end
    end
    lim  = (m_state == M_EXIT) ? EXT : (m_state == M_ENT) ? ENT : SIR;
    expd = tick && (m_ticks + 1 >= ((lim < 1) ? 1 : lim));
    inst = m_lvl & ~DMASK;
    dly  = m_lvl & DMASK;
    nst = m_state;
    ntrip = m_trip;
    case (m_state)
      M_DIS:  if (ok) nst = M_EXIT;
      M_EXIT: if (ok) nst = M_DIS; else if (expd) nst = M_ARM;
      M_ARM: begin
        if (ok) nst = M_DIS;
        else begin
          ntrip = ntrip | m_lvl;
          if (inst != 0) nst = M_ALM; else if (dly != 0) nst = M_ENT;
        end
      end
      M_ENT: begin
        if (ok) nst = M_DIS;
        else begin
          ntrip = ntrip | m_lvl;
          if (inst != 0 || expd) nst = M_ALM;
        end
      end
      default: if (ok) nst = M_DIS; else if (expd) nst = M_ARM;
    endcase
    if (nst != m_state) begin
      m_ticks = 0; nprog = 0;
      if (nst == M_DIS) ntrip = '0;
    end else if (tick) begin
      m_ticks++;
    end
    m_state = nst; m_prog = nprog; m_trip = ntrip;
    if (tick) begin
      for (int z = 0; z < NZ; z++) begin
        if (m_zs2[z] != m_lvl[z]) begin
          m_streak[z]++;
          if (m_streak[z] >= DEB) begin m_lvl[z] = m_zs2[z]; m_streak[z] = 0; end
        end else begin
          m_streak[z] = 0;
        end
      end
    end
    m_kprev = m_ks2; m_ks2 = m_ks1; m_ks1 = bus.keypad_in;
    m_zs2 = m_zs1; m_zs1 = bus.zone_in;
    m_n++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (m_valid) check("cycle", outs(), m_exp());
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int gap);
    $display("key %h hold %0d gap %0d", k, hold, gap);
    bus.keypad_in = k;
    steps(hold);
    bus.keypad_in = 4'h0;
    steps(gap);
  endtask

  task automatic enter_code(input int hold, input int gap);
    for (int i = 0; i < CLEN; i++) press(code_digit(i), hold, gap);
  endtask

  function automatic logic get_out(input int sel);
    case (sel)
      0:       return bus.alarm_siren;
      1:       return bus.is_armed;
      default: return bus.is_wait_delay;
    endcase
  endfunction

  task automatic wait_out(input int sel, input logic val, input int max_cyc, input string tag);
    int n;
    n = 0;
    while (get_out(sel) !== val && n < max_cyc) begin
      step();
      n++;
    end
    check(tag, {7'd0, get_out(sel)}, {7'd0, val});
  endtask

  // True when zone 0's debounced level will flip on the edge after next.
  function automatic bit flip_in_two();
    return (((m_n + 1) % DIV) == DIV - 1) && (m_streak[0] == DEB - 1) && (m_zs1[0] != m_lvl[0]);
  endfunction

  int act, hold, gap;
  bit found;

  initial begin
    bus.zone_in = '0;
    bus.keypad_in = 4'h0;
    reset = 1'b0;
    steps(3);
    reset = 1'b1;
    check("reset_state", outs(), 8'h00);

    $display("scenario arm");
    enter_code(1, 2);
    check("arm_exit_delay", outs(), 8'h08);
    wait_out(1, 1'b1, 40, "arm_reach_armed");
    check("arm_armed_outs", outs(), 8'h10);

    $display("scenario entry_disarm");
    bus.zone_in = 3'b100;
    wait_out(2, 1'b1, 30, "entry_wait");
    check("entry_outs", outs(), 8'h1C);
    bus.zone_in = '0;
    enter_code(1, 1);
    steps(2);
    check("disarm_outs", outs(), 8'h00);
    steps(12);

    $display("scenario instant_alarm");
    enter_code(1, 2);
    wait_out(1, 1'b1, 40, "alarm_armed");
    bus.zone_in = 3'b001;
    wait_out(0, 1'b1, 30, "alarm_siren_on");
    check("alarm_outs", outs(), 8'h31);
    bus.zone_in = '0;
    wait_out(0, 1'b0, 60, "alarm_siren_off");
    check("alarm_rearmed_outs", outs(), 8'h11);

    $display("scenario bad_code_glitch");
    press(4'h1, 1, 2); press(4'h2, 1, 2); press(4'h9, 1, 2); press(4'h3, 1, 2); press(4'h4, 1, 2);
    steps(2);
    check("bad_code_outs", outs(), 8'h11);
    bus.zone_in = 3'b001;
    steps(DIV);
    bus.zone_in = '0;
    steps(20);
    check("glitch_outs", outs(), 8'h11);

    $display("scenario priority");
    press(4'h1, 1, 2); press(4'h2, 1, 2); press(4'h3, 1, 2);
    steps(2);
    bus.zone_in = 3'b001;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (flip_in_two()) found = 1'b1;
      else step();
    end
    bus.keypad_in = 4'h4;
    step();
    bus.keypad_in = 4'h0;
    steps(3);
    check("priority_outs", outs(), 8'h00);
    steps(30);
    check("priority_no_siren", outs(), 8'h00);
    bus.zone_in = '0;
    steps(12);

    $display("scenario reset_abort");
    enter_code(1, 2);
    wait_out(1, 1'b1, 40, "reset_armed");
    bus.zone_in = 3'b001;
    wait_out(0, 1'b1, 30, "reset_alarm_on");
    bus.zone_in = '0;
    press(4'h1, 1, 2); press(4'h2, 1, 2);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("reset_abort_outs", outs(), 8'h00);
    press(4'h3, 1, 2); press(4'h4, 1, 2);
    steps(2);
    check("reset_no_pending", outs(), 8'h00);
    enter_code(1, 2);
    check("reset_code_from_digit0", outs(), 8'h08);
    steps(8);

    $display("scenario random");
    for (int a = 0; a < 300; a++) begin
      act  = $urandom_range(0, 9);
      hold = $urandom_range(1, 3);
      gap  = $urandom_range(1, 3);
      if (act < 3) begin
        $display("rand %0d code", a);
        enter_code(hold, gap);
      end else if (act < 5) begin
        $display("rand %0d single key", a);
        press(4'($urandom_range(1, 15)), hold, gap);
      end else if (act < 8) begin
        bus.zone_in = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
        $display("rand %0d zones %b", a, bus.zone_in);
        steps($urandom_range(1, 16));
      end else if (act == 8 || $urandom_range(0, 3) != 0) begin
        $display("rand %0d idle", a);
        steps(20);
      end else begin
        $display("rand %0d reset pulse", a);
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
